op_decoder: RTL
===============

OP_DECODER -- requirements
Module: op_decoder

Interface
REQ-001 Parameter: DEPTH, 2, number of decoded-op buffer entries (legal values 2 or 4).
REQ-002 Parameter: CNT_W, 8, width of the illegal-instruction counter.
REQ-003 The block SHALL have exactly one clock and a synchronous, active-low reset.
REQ-004 Clk  in  1  rising-edge clock for all state.
REQ-005 Reset  in  1  synchronous, active-low reset.
REQ-006 InValid  in  1  instruction word on InInst is valid.
REQ-007 InReady  out  1  block accepts InInst this cycle.
REQ-008 InInst  in  9  instruction: [8:6] opcode, [5:3] rd, [2:0] rs.
REQ-009 OutValid  out  1  head buffer entry is valid.
REQ-010 OutReady  in  1  ALU consumes the head entry this cycle.
REQ-011 AluOp  out  3  decoded ALU operation, encoded as op_mne from package Definitions.
REQ-012 OutRd  out  3  destination register index.
REQ-013 OutRs  out  3  source register index.
REQ-014 Error  out  1  high while in ERROR state.
REQ-015 ErrClr  in  1  single-cycle pulse that leaves ERROR.
REQ-016 IllegalCnt  out  CNT_W  count of rejected instructions.
REQ-017 Occupancy  out  $clog2(DEPTH)+1  number of buffered entries.

Function
REQ-018 Opcode decode SHALL be: 010 ADD, 110 LSL, 100 XOR, 101 AND, 011 SUB, 111 MOV; 000 and 001 are illegal.
REQ-019 A transfer-in SHALL occur when InValid && InReady; InReady SHALL be 1 only in RUN with Occupancy < DEPTH, and SHALL NOT depend on OutReady.
REQ-020 A legal transfer-in SHALL write {AluOp, rd, rs} to the buffer tail; the entry SHALL be visible at the outputs no earlier than the next cycle (1-cycle latency when the buffer is empty).
REQ-021 A transfer-out SHALL occur when OutValid && OutReady and SHALL retire the head entry; entries SHALL leave in arrival order.
REQ-022 While OutValid && !OutReady, AluOp, OutRd and OutRs SHALL hold stable.
REQ-023 When OutValid = 0, AluOp, OutRd and OutRs SHALL be driven to 0.
REQ-024 A simultaneous transfer-in and transfer-out SHALL leave Occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-025 An illegal transfer-in SHALL NOT be buffered, SHALL increment IllegalCnt saturating at 2^CNT_W-1, and SHALL move the FSM to ERROR on the next cycle.
REQ-026 FSM states: RUN and ERROR. RUN->ERROR on an illegal transfer-in. ERROR->RUN on ErrClr=1. ErrClr in RUN SHALL be ignored.
REQ-027 In ERROR, InReady SHALL be 0, Error SHALL be 1, and the buffer SHALL continue to drain through OutReady.
REQ-028 OutValid SHALL equal (Occupancy != 0).

Reset
REQ-029 When Reset = 0 at a rising Clk edge, the block SHALL set: FSM to RUN, Occupancy 0, OutValid 0, AluOp/OutRd/OutRs 0, Error 0, IllegalCnt 0, and pointers 0.
REQ-030 Reset SHALL take priority over any simultaneous handshake or ErrClr; buffered entries SHALL be discarded, including a reset asserted mid-operation or in ERROR.
REQ-031 While Reset = 0, InReady SHALL be 0.

Verification
REQ-032 Single op: InInst=9'b010_001_010, OutReady=1 -> next cycle OutValid=1, AluOp=ADD, OutRd=1, OutRs=2; one cycle later OutValid=0.
REQ-033 Backpressure: OutReady=0 with DEPTH=2; push SUB then MOV -> InReady=0 and Occupancy=2; third word is held off; raise OutReady -> SUB then MOV, outputs stable until each pop.
REQ-034 Illegal op: with one entry buffered, push 9'b001_000_000 -> IllegalCnt=1, Error=1, InReady=0; buffered entry still drains; ErrClr pulse -> RUN, InReady=1.
REQ-035 Saturation: send 256 illegal words with ErrClr between each -> IllegalCnt stops at 255.
REQ-036 Simultaneous push and pop at Occupancy=1, continuous stream of all six legal ops -> Occupancy stays 1 and order is preserved.
REQ-037 Reset mid-stream in ERROR with Occupancy=2 -> next cycle OutValid=0, Occupancy=0, Error=0, IllegalCnt=0, InReady=1 once Reset=1.

Source files
------------

// File: rtl/op_decoder.sv
// op_decoder
// ----------
// Decodes 9-bit instruction words ([8:6] opcode, [5:3] rd, [2:0] rs) into
// ALU operations and queues them in a small in-order buffer that feeds the ALU.
// An illegal opcode is dropped and counted, and the block enters ERROR.
// While in ERROR no new words are accepted, but the buffer keeps draining.
// An ErrClr pulse returns the block to RUN.
//
// Handshakes (both sides): a word moves when valid && ready on the same rising
// Clk edge. InReady never depends on OutReady, so there is no combinational
// path from the ALU side to the instruction side. While OutValid is high and
// OutReady is low, the head entry (AluOp/OutRd/OutRs) holds steady.
//
// Ports
//   Clk        in   rising-edge clock
//   Reset      in   synchronous, active-low reset
//   InValid    in   InInst carries a word
//   InReady    out  word accepted this cycle (RUN, buffer not full, not in reset)
//   InInst     in   instruction word
//   OutValid   out  head entry valid (Occupancy != 0)
//   OutReady   in   ALU consumes the head entry
//   AluOp      out  decoded operation (0 when OutValid is low)
//   OutRd      out  destination register (0 when OutValid is low)
//   OutRs      out  source register (0 when OutValid is low)
//   Error      out  high while in ERROR (this is the FSM state bit)
//   ErrClr     in   leaves ERROR; ignored in RUN
//   IllegalCnt out  saturating count of rejected words
//   Occupancy  out  number of buffered entries

package Definitions;
    typedef enum logic [2:0] {
        NOP = 3'b000,
        ADD = 3'b010,
        SUB = 3'b011,
        XOR = 3'b100,
        AND = 3'b101,
        LSL = 3'b110,
        MOV = 3'b111
    } op_mne;
endpackage

module op_decoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [8:0]               InInst,
    output logic                     OutValid,
    input  logic                     OutReady,
    output Definitions::op_mne       AluOp,
    output logic [2:0]               OutRd,
    output logic [2:0]               OutRs,
    output logic                     Error,
    input  logic                     ErrClr,
    output logic [CNT_W-1:0]         IllegalCnt,
    output logic [$clog2(DEPTH):0]   Occupancy
);
    import Definitions::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_ERROR = 1'b1
    } state_t;

    typedef struct packed {
        op_mne      op;
        logic [2:0] rd;
        logic [2:0] rs;
    } entry_t;

    state_t             r_state;
    state_t             w_state_nxt;
    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [OCC_W-1:0]   r_occ;
    logic [CNT_W-1:0]   r_cnt;

    op_mne              w_op;
    logic               w_legal;
    logic               w_push;
    logic               w_push_ok;
    logic               w_illegal;
    logic               w_pop;
    entry_t             w_head;

    // Opcode decode; 000 and 001 are the illegal encodings.
    always_comb begin
        w_op    = NOP;
        w_legal = 1'b0;
        case (InInst[8:6])
            3'b010:  begin w_op = ADD; w_legal = 1'b1; end
            3'b011:  begin w_op = SUB; w_legal = 1'b1; end
            3'b100:  begin w_op = XOR; w_legal = 1'b1; end
            3'b101:  begin w_op = AND; w_legal = 1'b1; end
            3'b110:  begin w_op = LSL; w_legal = 1'b1; end
            3'b111:  begin w_op = MOV; w_legal = 1'b1; end
            default: begin w_op = NOP; w_legal = 1'b0; end
        endcase
    end

    assign w_push    = InValid && InReady;
    assign w_push_ok = w_push && w_legal;
    assign w_illegal = w_push && !w_legal;
    assign w_pop     = OutValid && OutReady;

    // FSM state register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and state-derived outputs. InReady also looks at the
    // live Reset input so nothing is accepted while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        InReady     = 1'b0;
        Error       = 1'b0;
        case (r_state)
            S_RUN: begin
                InReady = Reset && (r_occ < DEPTH_C);
                if (w_illegal) begin
                    w_state_nxt = S_ERROR;
                end
            end
            S_ERROR: begin
                Error = 1'b1;
                if (ErrClr) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // Buffer storage carries no reset; Occupancy alone decides what is valid.
    always_ff @(posedge Clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= '{op: w_op, rd: InInst[5:3], rs: InInst[2:0]};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two (2 or 4).
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Illegal-word counter, saturating at all ones.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_cnt <= '0;
        end else if (w_illegal && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_head     = r_mem[r_rptr];
    assign OutValid   = (r_occ != '0);
    assign AluOp      = OutValid ? w_head.op : NOP;
    assign OutRd      = OutValid ? w_head.rd : 3'b000;
    assign OutRs      = OutValid ? w_head.rs : 3'b000;
    assign IllegalCnt = r_cnt;
    assign Occupancy  = r_occ;

endmodule
